// File: rtl/tr_bist_pkg.sv
// Shared BIST package: FSM state encoding and default polynomial/seed,
// common to the LFSR pattern generator and the signature analyzer.
package tr_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_CAP,
        ST_SHIFT,
        ST_FIN
    } bist_state_t;

    // x^16 + x^12 + x^5 + 1, x^16 implicit
    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'h0000;

endpackage

// File: rtl/tr_signature_analyzer_if.sv
// Control/status bundle of the signature analyzer.
// master: test controller (drives START/SE/SI); slave: analyzer.
interface tr_signature_analyzer_if #(
    parameter int SIG_W = 16,
    parameter int PC_W  = 3
);

    logic             START;
    logic             SE;
    logic             SI;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic             ERR;
    logic [SIG_W-1:0] SIG;
    logic [PC_W-1:0]  PAT_CNT;

    modport master (
        output START, SE, SI,
        input  BUSY, DONE, PASS, ERR, SIG, PAT_CNT
    );

    modport slave (
        input  START, SE, SI,
        output BUSY, DONE, PASS, ERR, SIG, PAT_CNT
    );

endinterface

// File: rtl/tr_sisr.sv
// Galois-form serial-input signature register with seed load and enable.
// Ports: clk/rst, load (reseed), en (compact si), sig (state), sig_next.
module tr_sisr
    import tr_bist_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             si,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_next
);

    logic fb;

    // sig_next is exported so the top can judge PASS on the same
    // edge that absorbs the last bit.
    always_comb begin
        fb       = sig[SIG_W-1] ^ si;
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/tr_signature_analyzer.sv
// Scan-out response compactor: FSM tracks capture/shift protocol, counts
// bits/patterns, compacts via tr_sisr and compares against GOLDEN.
// Ports: CLK, RST (async, active-high), bus (START/SE/SI in; status out).
module tr_signature_analyzer
    import tr_bist_pkg::*;
#(
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] POLY     = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED     = SIG_W'(DEF_SEED),
    parameter int               SCAN_LEN = 60,
    parameter int               NUM_PAT  = 4,
    parameter logic [SIG_W-1:0] GOLDEN   = '0
) (
    input logic                  CLK,
    input logic                  RST,
    tr_signature_analyzer_if.slave bus
);

    localparam int CNT_W = $clog2(SCAN_LEN + 1);
    localparam int PC_W  = $clog2(NUM_PAT + 1);

    bist_state_t      state;
    logic [CNT_W-1:0] bit_cnt;
    logic [PC_W-1:0]  pat_cnt;
    logic             busy;
    logic             done;
    logic             pass;
    logic             err;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] sig_next;
    logic             shift_en;
    logic             last_bit;
    logic             last_pat;

    // START wins over everything, so it also blocks compaction.
    assign shift_en = (state == ST_SHIFT) && bus.SE && !bus.START;
    assign last_bit = (bit_cnt == CNT_W'(SCAN_LEN - 1));
    assign last_pat = (pat_cnt == PC_W'(NUM_PAT - 1));

    tr_sisr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_sisr (
        .clk      (CLK),
        .rst      (RST),
        .load     (bus.START),
        .en       (shift_en),
        .si       (bus.SI),
        .sig      (sig),
        .sig_next (sig_next)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            pat_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err     <= 1'b0;
        end else if (bus.START) begin
            state   <= ST_WAIT_CAP;
            bit_cnt <= '0;
            pat_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            err     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                end
                ST_WAIT_CAP: begin
                    // SE=1 here means unloaded chain contents: discard.
                    if (!bus.SE) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (bus.SE) begin
                        if (last_bit) begin
                            bit_cnt <= '0;
                            pat_cnt <= pat_cnt + PC_W'(1);
                            if (last_pat) begin
                                state <= ST_FIN;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= (sig_next == GOLDEN);
                            end else begin
                                state <= ST_WAIT_CAP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (bit_cnt != '0) begin
                        // Capture mid-unload corrupts the response.
                        state <= ST_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                        err   <= 1'b1;
                    end
                    // SE=0 with bit_cnt==0: repeated capture, hold.
                end
                ST_FIN: begin
                end
            endcase
        end
    end

    assign bus.BUSY    = busy;
    assign bus.DONE    = done;
    assign bus.PASS    = pass;
    assign bus.ERR     = err;
    assign bus.SIG     = sig;
    assign bus.PAT_CNT = pat_cnt;

endmodule
